// File: rtl/fp_accumulator.sv
// Sequential FP32 accumulator: one product per transaction through ALIGN/ADD/NORM.
// Define FP_ACC_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_accumulator (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_first,
   input  logic        in_last,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [31:0] acc_value
);

`ifdef FP_ACC_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StAlign, StAdd, StNorm} state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        last_q, last_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d, sub_q, sub_d;
   logic [26:0] big_q, big_d, small_q, small_d;
   logic [27:0] sum_q, sum_d;
   logic [31:0] acc_q, acc_d, out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;

   // Alignment datapath (used in StAlign)
   logic        a_zero, b_zero, a_ge_b;
   logic [23:0] a_man, b_man, big_man, small_man;
   logic [7:0]  big_exp, small_exp, exp_diff;
   logic [4:0]  shamt;
   logic [53:0] shifted;
   logic [26:0] small_al;

   always_comb begin
      a_zero    = (a_q[30:23] == 8'd0);
      b_zero    = (b_q[30:23] == 8'd0);
      a_man     = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
      b_man     = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
      a_ge_b    = {a_q[30:23], a_man} >= {b_q[30:23], b_man};
      big_exp   = a_ge_b ? a_q[30:23] : b_q[30:23];
      small_exp = a_ge_b ? b_q[30:23] : a_q[30:23];
      big_man   = a_ge_b ? a_man : b_man;
      small_man = a_ge_b ? b_man : a_man;
      exp_diff  = big_exp - small_exp;
      shamt     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
      shifted   = {small_man, 30'd0} >> shamt;
      // Everything shifted below the round bit folds into sticky
      small_al  = {shifted[53:28], shifted[27] | (|shifted[26:0])};
   end

   // Normalization and rounding datapath (used in StNorm)
   logic [4:0]         lz;
   logic [26:0]        man_n;
   logic signed [9:0]  exp_n, exp_r;
   logic               round_up;
   logic [24:0]        man_r;
   logic [22:0]        frac;
   logic [31:0]        result;

   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum_q[i]) lz = 5'(26 - i);
      end
      if (sum_q[27]) begin
         man_n = {sum_q[27:2], sum_q[1] | sum_q[0]};
         exp_n = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         man_n = sum_q[26:0] << lz;
         exp_n = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
      end
      round_up = RoundEn & man_n[2] & (man_n[1] | man_n[0] | man_n[3]);
      man_r    = {1'b0, man_n[26:3]} + {24'd0, round_up};
      exp_r    = exp_n + $signed({9'd0, man_r[24]});
      frac     = man_r[24] ? man_r[23:1] : man_r[22:0];
      if (sum_q == 28'd0) begin
         result = 32'd0;
      end else if (exp_r > 10'sd254) begin
         result = {sign_q, 31'h7F7FFFFF};
      end else if (exp_r < 10'sd1) begin
         result = 32'd0;
      end else begin
         result = {sign_q, exp_r[7:0], frac};
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      last_d      = last_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      sub_d       = sub_q;
      big_d       = big_q;
      small_d     = small_q;
      sum_d       = sum_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in_data;
               b_d     = in_first ? 32'd0 : acc_q;
               last_d  = in_last;
               state_d = StAlign;
            end
         end
         StAlign: begin
            exp_d   = big_exp;
            sign_d  = a_ge_b ? a_q[31] : b_q[31];
            sub_d   = a_q[31] ^ b_q[31];
            big_d   = {big_man, 3'b000};
            small_d = small_al;
            state_d = StAdd;
         end
         StAdd: begin
            sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
            state_d = StNorm;
         end
         StNorm: begin
            acc_d = result;
            if (last_q) begin
               out_data_d  = result;
               out_valid_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         last_q      <= 1'b0;
         exp_q       <= 8'd0;
         sign_q      <= 1'b0;
         sub_q       <= 1'b0;
         big_q       <= 27'd0;
         small_q     <= 27'd0;
         sum_q       <= 28'd0;
         acc_q       <= 32'd0;
         out_data_q  <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         last_q      <= last_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         sub_q       <= sub_d;
         big_q       <= big_d;
         small_q     <= small_d;
         sum_q       <= sum_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign acc_value = acc_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator; expected results hand-computed from FP32 arithmetic.
module tb_fp_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_first;
   logic        in_last;
   logic        out_valid;
   logic [31:0] out_data;
   logic [31:0] acc_value;

   int total = 0;
   int bad   = 0;

   fp_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_data  (out_data),
      .acc_value (acc_value)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge of cycle 1 after the accept.
   task automatic send(input logic [31:0] d, input logic f, input logic l);
      int n = 0;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_first = f;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'hDEADBEEF;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   // Cycle index (1-based from the accept) of the out_valid pulse, 0 if none within 8.
   task automatic watch(output int cyc, output logic [31:0] data);
      cyc  = 0;
      data = 32'd0;
      for (int k = 1; k <= 8; k++) begin
         if (out_valid) begin
            cyc  = k;
            data = out_data;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 32'd0;
      in_first = 1'b0;
      in_last = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: ready=%0b valid=%0b required 1/0", in_ready, out_valid);
      end
      total++;
      if (out_data !== 32'd0 || acc_value !== 32'd0) begin
         bad++;
         $display("FAIL reset_data: out=%h acc=%h required 0/0", out_data, acc_value);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
      end
   endtask

   task automatic test_single();
      send(32'hC0A00000, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_busy c%0d: ready=%0b valid=%0b required 0/0",
                     k, in_ready, out_valid);
         end
         @(negedge clk);
      end
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hC0A00000) begin
         bad++;
         $display("FAIL single_out: ready=%0b valid=%0b data=%h required 1/1/c0a00000",
                  in_ready, out_valid, out_data);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_pulse: out_valid=%0b required 0", out_valid);
      end
   endtask

   task automatic test_basic_sum();
      int c;
      logic [31:0] d;
      send(32'h3F800000, 1'b1, 1'b0);
      watch(c, d);
      total++;
      if (c !== 0 || acc_value !== 32'h3F800000) begin
         bad++;
         $display("FAIL basic_partial: pulse=%0d acc=%h required 0/3f800000", c, acc_value);
      end
      send(32'h40000000, 1'b0, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== 32'h40400000) begin
         bad++;
         $display("FAIL basic_sum: cycle=%0d data=%h required 4/40400000", c, d);
      end
      total++;
      if (acc_value !== 32'h40400000) begin
         bad++;
         $display("FAIL basic_acc: acc=%h required 40400000", acc_value);
      end
   endtask

   task automatic test_cancel();
      int c;
      logic [31:0] d;
      send(32'h3FC00000, 1'b1, 1'b0);
      watch(c, d);
      send(32'hBFC00000, 1'b0, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== 32'h00000000) begin
         bad++;
         $display("FAIL cancel: cycle=%0d data=%h required 4/00000000", c, d);
      end
   endtask

   task automatic test_round();
      int c;
      logic [31:0] d;
      logic [31:0] exp_val;
`ifdef FP_ACC_ROUND_EN
      exp_val = 32'h3F800001;
`else
      exp_val = 32'h3F800000;
`endif
      send(32'h3F800000, 1'b1, 1'b0);
      watch(c, d);
      send(32'h33C00000, 1'b0, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== exp_val) begin
         bad++;
         $display("FAIL round: cycle=%0d data=%h required 4/%h", c, d, exp_val);
      end
   endtask

   task automatic test_saturate();
      int c;
      logic [31:0] d;
      send(32'h7F7FFFFF, 1'b1, 1'b0);
      watch(c, d);
      send(32'h7F7FFFFF, 1'b0, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== 32'h7F7FFFFF) begin
         bad++;
         $display("FAIL saturate: cycle=%0d data=%h required 4/7f7fffff", c, d);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      logic [31:0] d;
      send(32'h3F800000, 1'b1, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== 32'h3F800000) begin
         bad++;
         $display("FAIL b2b_first: cycle=%0d data=%h required 4/3f800000", c, d);
      end
      // Accepted in the same cycle as the previous pulse; sum carries across in_last
      send(32'h40000000, 1'b0, 1'b1);
      watch(c, d);
      total++;
      if (c !== 4 || d !== 32'h40400000) begin
         bad++;
         $display("FAIL b2b_second: cycle=%0d data=%h required 4/40400000", c, d);
      end
   endtask

   task automatic test_ignore();
      in_valid = 1'b0;
      in_data  = 32'h12345678;
      in_first = 1'b1;
      in_last  = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (acc_value !== 32'h40400000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL ignore: acc=%h ready=%0b valid=%0b required 40400000/1/0",
                  acc_value, in_ready, out_valid);
      end
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset_mid();
      int c;
      logic [31:0] d;
      send(32'h40000000, 1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_value !== 32'd0 ||
          out_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid: ready=%0b valid=%0b acc=%h out=%h required 1/0/0/0",
                  in_ready, out_valid, acc_value, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_release: in_ready=%0b required 1", in_ready);
      end
      watch(c, d);
      total++;
      if (c !== 0 || acc_value !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_after: pulse=%0d acc=%h required 0/0", c, acc_value);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_basic_sum();
      test_cancel();
      test_round();
      test_saturate();
      test_back_to_back();
      test_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
